// File: rtl/orb_pkg.sv
// Shared definitions for the ORB feature stream: packet type codes, packet length,
// serializer FSM states and the feature record exchanged between mux and serializer.
package orb_pkg;

    localparam logic [3:0] PKT_TYPE_FEATURE = 4'h1;
    localparam logic [3:0] PKT_TYPE_TRAILER = 4'hF;

    localparam int FEATURE_PACKET_WORDS = 10;

    localparam int ORB_COORD_BITS      = 10;
    localparam int ORB_DESCRIPTOR_BITS = 256;
    localparam int ORB_LEVEL_BITS      = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_COORD   = 3'd2,
        ST_DESC    = 3'd3,
        ST_TRAILER = 3'd4,
        ST_CSUM    = 3'd5
    } ser_state_e;

    typedef struct packed {
        logic [ORB_DESCRIPTOR_BITS-1:0] descriptor;
        logic [ORB_COORD_BITS-1:0]      x;
        logic [ORB_COORD_BITS-1:0]      y;
        logic [ORB_LEVEL_BITS-1:0]      level;
    } feature_t;

endpackage

// File: rtl/feature_packet_checksum.sv
// XOR accumulator over the accepted words of one output packet.
// Only compiled when ORB_FEATURE_SERIALIZER_CHECKSUM_EN is defined.
`ifdef ORB_FEATURE_SERIALIZER_CHECKSUM_EN
module feature_packet_checksum
    import orb_pkg::*;
(
    input  logic        clk,
    input  logic        i_clear,
    input  logic        i_update,
    input  logic [31:0] i_data,
    output logic [31:0] o_csum
);

    logic [31:0] r_acc;

    // Cleared whenever the serializer sits idle, so every packet starts from zero.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_acc <= '0;
        end else if (i_update) begin
            r_acc <= r_acc ^ i_data;
        end
    end

    assign o_csum = r_acc;

endmodule
`endif

// File: rtl/orb_feature_serializer.sv
// Serializes accepted ORB features into 32-bit framed words and emits a per-frame
// trailer with the feature count. Optional CSUM word via ORB_FEATURE_SERIALIZER_CHECKSUM_EN.
module orb_feature_serializer
    import orb_pkg::*;
#(
    parameter int COORD_BITS      = 10,
    parameter int DESCRIPTOR_BITS = 256,
    parameter int LEVEL_BITS      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DESCRIPTOR_BITS-1:0] in_descriptor,
    input  logic [COORD_BITS-1:0]      in_feature_x,
    input  logic [COORD_BITS-1:0]      in_feature_y,
    input  logic [LEVEL_BITS-1:0]      in_level,
    output logic                       out_feature_ready,
    input  logic                       in_frame_end,
    output logic [31:0]                out_data,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       in_ready
);

    localparam int         DESC_WORDS    = FEATURE_PACKET_WORDS - 2;
    localparam logic [2:0] LAST_DESC_IDX = 3'(DESC_WORDS - 1);

    ser_state_e                 r_state;
    logic                       r_valid;
    logic                       r_last;
    logic                       r_ready;
    logic                       r_pending;
    logic [31:0]                r_data;
    logic [15:0]                r_count;
    logic [2:0]                 r_widx;
    logic [COORD_BITS-1:0]      r_x;
    logic [COORD_BITS-1:0]      r_y;
    logic [DESCRIPTOR_BITS-1:0] r_desc;

    logic        w_feat_hs;
    logic        w_out_hs;
    logic        w_trl_hs;
    logic [2:0]  w_widx_nxt;
    logic [15:0] w_count_inc;
    logic [31:0] w_header;
    logic [31:0] w_coord;
    logic [31:0] w_desc_nxt;
    logic [31:0] w_trailer;
    logic        w_unused_level;

    assign w_feat_hs   = (r_state == ST_IDLE) && in_valid && r_ready;
    assign w_out_hs    = r_valid && in_ready;
    assign w_trl_hs    = (r_state == ST_TRAILER) && w_out_hs;
    assign w_widx_nxt  = r_widx + 3'd1;
    assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;

    assign w_header   = {PKT_TYPE_FEATURE, in_level[11:0], 16'h0000};
    assign w_coord    = {16'(r_y), 16'(r_x)};
    assign w_desc_nxt = r_desc[{w_widx_nxt, 5'b00000} +: 32];
    assign w_trailer  = {PKT_TYPE_TRAILER, 12'h000, r_count};

    // Only the low 12 level bits travel in the header.
    assign w_unused_level = ^in_level[LEVEL_BITS-1:12];

`ifdef ORB_FEATURE_SERIALIZER_CHECKSUM_EN
    logic [31:0] w_csum_acc;
    logic [31:0] w_csum_word;

    feature_packet_checksum u_csum (
        .clk      (clk),
        .i_clear  (r_state == ST_IDLE),
        .i_update (w_out_hs),
        .i_data   (r_data),
        .o_csum   (w_csum_acc)
    );

    // Word currently on the bus is folded in as it is accepted.
    assign w_csum_word = w_csum_acc ^ r_data;
    localparam logic TRAILER_IS_LAST = 1'b0;
`else
    localparam logic TRAILER_IS_LAST = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (w_feat_hs) begin
            r_x    <= in_feature_x;
            r_y    <= in_feature_y;
            r_desc <= in_descriptor;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_data    <= '0;
            r_ready   <= 1'b0;
            r_count   <= '0;
            r_pending <= 1'b0;
            r_widx    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_feat_hs) begin
                        r_state <= ST_HEADER;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_data  <= w_header;
                        r_ready <= 1'b0;
                        r_count <= w_count_inc;
                    end else if (r_pending) begin
                        r_state <= ST_TRAILER;
                        r_valid <= 1'b1;
                        r_last  <= TRAILER_IS_LAST;
                        r_data  <= w_trailer;
                        r_ready <= 1'b0;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (w_out_hs) begin
                        r_state <= ST_COORD;
                        r_data  <= w_coord;
                    end
                end
                ST_COORD: begin
                    if (w_out_hs) begin
                        r_state <= ST_DESC;
                        r_widx  <= '0;
                        r_data  <= r_desc[31:0];
                    end
                end
                ST_DESC: begin
                    if (w_out_hs) begin
                        r_widx <= w_widx_nxt;
                        if (r_widx == LAST_DESC_IDX) begin
`ifdef ORB_FEATURE_SERIALIZER_CHECKSUM_EN
                            r_state <= ST_CSUM;
                            r_data  <= w_csum_word;
                            r_last  <= 1'b1;
`else
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_ready <= 1'b1;
`endif
                        end else begin
                            r_data <= w_desc_nxt;
                            r_last <= TRAILER_IS_LAST && (w_widx_nxt == LAST_DESC_IDX);
                        end
                    end
                end
                ST_TRAILER: begin
                    if (w_out_hs) begin
                        r_count <= '0;
`ifdef ORB_FEATURE_SERIALIZER_CHECKSUM_EN
                        r_state <= ST_CSUM;
                        r_data  <= w_csum_word;
                        r_last  <= 1'b1;
`else
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_ready <= 1'b1;
`endif
                    end
                end
`ifdef ORB_FEATURE_SERIALIZER_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_out_hs) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase

            // A new frame-end pulse wins over the clear from an accepted trailer.
            if (w_trl_hs) begin
                r_pending <= 1'b0;
            end
            if (in_frame_end) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign out_data          = r_data;
    assign out_valid         = r_valid;
    assign out_last          = r_last;
    assign out_feature_ready = r_ready;

endmodule

// File: tb/tb_orb_feature_serializer.sv
// Self-checking bench for orb_feature_serializer: queue-based reference model plus
// literal expectations; honours ORB_FEATURE_SERIALIZER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_orb_feature_serializer;
    import orb_pkg::*;

`ifdef ORB_FEATURE_SERIALIZER_CHECKSUM_EN
    localparam int PKT_W = FEATURE_PACKET_WORDS + 1;
    localparam int TRL_W = 2;
`else
    localparam int PKT_W = FEATURE_PACKET_WORDS;
    localparam int TRL_W = 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [255:0] in_descriptor = '0;
    logic [9:0]   in_feature_x = '0;
    logic [9:0]   in_feature_y = '0;
    logic [15:0]  in_level = '0;
    logic         out_feature_ready;
    logic         in_frame_end = 1'b0;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_last;
    logic         in_ready = 1'b1;

    always #5 clk = ~clk;

    orb_feature_serializer #(
        .COORD_BITS(10), .DESCRIPTOR_BITS(256), .LEVEL_BITS(16)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_descriptor(in_descriptor),
        .in_feature_x(in_feature_x), .in_feature_y(in_feature_y), .in_level(in_level),
        .out_feature_ready(out_feature_ready), .in_frame_end(in_frame_end),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .in_ready(in_ready)
    );

    typedef struct {
        logic [31:0] d;
        bit          last;
        bit          trl;
    } exp_t;

    exp_t        q[$];
    logic [31:0] log_d[$];
    bit          log_l[$];
    int          log_c[$];
    bit          m_pending = 1'b0;
    bit          m_ready = 1'b0;
    logic [15:0] m_count = '0;
    int          cyc = 0;
    int          hs_cyc = 0;
    int          ntests = 0;
    int          nfail = 0;
    int          bp_mode = 0;

    logic         s_in_valid, s_in_ready, s_frame_end, s_out_valid, s_out_last;
    logic [31:0]  s_out_data;
    logic [255:0] s_desc;
    logic [9:0]   s_x, s_y;
    logic [15:0]  s_level;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_feature();
        logic [31:0] w [FEATURE_PACKET_WORDS];
        logic [31:0] x;
        w[0] = {PKT_TYPE_FEATURE, s_level[11:0], 16'h0000};
        w[1] = {6'b0, s_y, 6'b0, s_x};
        for (int k = 0; k < 8; k++) w[2+k] = s_desc[32*k +: 32];
        x = '0;
        for (int i = 0; i < FEATURE_PACKET_WORDS; i++) begin
            x = x ^ w[i];
            q.push_back(exp_t'{d: w[i], last: (PKT_W == FEATURE_PACKET_WORDS) && (i == FEATURE_PACKET_WORDS-1), trl: 1'b0});
        end
        if (PKT_W != FEATURE_PACKET_WORDS) q.push_back(exp_t'{d: x, last: 1'b1, trl: 1'b0});
    endtask

    task automatic push_trailer();
        logic [31:0] t;
        t = {PKT_TYPE_TRAILER, 12'h000, m_count};
        q.push_back(exp_t'{d: t, last: (TRL_W == 1), trl: 1'b1});
        if (TRL_W == 2) q.push_back(exp_t'{d: t, last: 1'b1, trl: 1'b0});
    endtask

    // Reference model: advances on each rising edge using inputs sampled mid-cycle.
    always @(posedge clk) begin : model
        bit was_empty;
        cyc++;
        if (!reset) begin
            q.delete();
            m_pending = 1'b0;
            m_count = '0;
            m_ready = 1'b0;
        end else begin
            if (s_out_valid && s_in_ready) begin
                log_d.push_back(s_out_data);
                log_l.push_back(s_out_last);
                log_c.push_back(cyc);
            end
            was_empty = (q.size() == 0);
            if (!was_empty && s_in_ready) begin
                if (q[0].trl) begin
                    m_pending = 1'b0;
                    m_count = '0;
                end
                void'(q.pop_front());
            end
            if (was_empty) begin
                if (m_ready && s_in_valid) begin
                    push_feature();
                    hs_cyc = cyc;
                    if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                end else if (m_pending) begin
                    push_trailer();
                end
            end
            if (s_frame_end) m_pending = 1'b1;
            m_ready = (q.size() == 0);
        end
    end

    // Compare process: samples and checks every falling edge.
    always @(negedge clk) begin
        s_in_valid  = in_valid;
        s_in_ready  = in_ready;
        s_frame_end = in_frame_end;
        s_out_valid = out_valid;
        s_out_last  = out_last;
        s_out_data  = out_data;
        s_desc      = in_descriptor;
        s_x         = in_feature_x;
        s_y         = in_feature_y;
        s_level     = in_level;
        if (!reset) begin
            check("reset_valid", 32'(out_valid), 32'd0);
            check("reset_feat_ready", 32'(out_feature_ready), 32'd0);
        end else begin
            check("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("out_data", out_data, q[0].d);
                check("out_last", 32'(out_last), 32'(q[0].last));
            end
            check("feat_ready", 32'(out_feature_ready), 32'(m_ready));
        end
    end

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       in_ready = 1'b1;
            1:       in_ready = ~in_ready;
            default: in_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic send_feature(input logic [15:0] lv, input logic [9:0] x, input logic [9:0] y,
                                input logic [255:0] d);
        bit done;
        done = 1'b0;
        in_level = lv;
        in_feature_x = x;
        in_feature_y = y;
        in_descriptor = d;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (out_feature_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) check("feature_accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic pulse_frame_end();
        in_frame_end = 1'b1;
        @(posedge clk);
        #1;
        in_frame_end = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !m_pending && m_ready) done = 1'b1;
        end
        if (!done) check("idle_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_trailer(input string name, input int idx, input logic [31:0] exp);
        check(name, log_d[idx], exp);
        if (TRL_W == 2) check({name, "_csum"}, log_d[idx+1], exp);
        check({name, "_last"}, 32'(log_l[idx+TRL_W-1]), 32'd1);
    endtask

    logic [255:0] desc_a;
    int base;

    initial begin
        for (int k = 0; k < 8; k++) desc_a[32*k +: 32] = 32'hA0A0_0000 + 32'(k);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_feat_ready", 32'(out_feature_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", 32'(out_feature_ready), 32'd1);

        // Single feature, in_ready held high
        base = log_d.size();
        send_feature(16'd3, 10'h12, 10'h34, desc_a);
        wait_idle();
        check("s1_header", log_d[base], 32'h1003_0000);
        check("s1_coord", log_d[base+1], 32'h0034_0012);
        for (int k = 0; k < 8; k++) check("s1_desc", log_d[base+2+k], 32'hA0A0_0000 + 32'(k));
        for (int i = 0; i < PKT_W; i++) check("s1_last", 32'(log_l[base+i]), 32'(i == PKT_W-1));
`ifdef ORB_FEATURE_SERIALIZER_CHECKSUM_EN
        check("s1_csum", log_d[base+10], 32'h1037_0012);
`endif
        check("s1_header_latency", 32'(log_c[base] - hs_cyc), 32'd1);
        check("s1_last_latency", 32'(log_c[base+PKT_W-1] - hs_cyc), 32'(PKT_W));
        check("s1_word_count", 32'(log_d.size() - base), 32'(PKT_W));

        // Same feature under toggling backpressure
        bp_mode = 1;
        base = log_d.size();
        send_feature(16'd3, 10'h12, 10'h34, desc_a);
        wait_idle();
        bp_mode = 0;
        check("bp_word_count", 32'(log_d.size() - base), 32'(PKT_W));
        check("bp_header", log_d[base], 32'h1003_0000);
        check("bp_coord", log_d[base+1], 32'h0034_0012);
        for (int k = 0; k < 8; k++) check("bp_desc", log_d[base+2+k], 32'hA0A0_0000 + 32'(k));

        // Frame counts
        base = log_d.size();
        pulse_frame_end();
        wait_idle();
        check_trailer("trl_two", base, 32'hF000_0002);
        for (int n = 0; n < 3; n++) send_feature(16'(n), 10'(n), 10'(n+1), {8{$urandom()}});
        wait_idle();
        base = log_d.size();
        pulse_frame_end();
        wait_idle();
        check_trailer("trl_three", base, 32'hF000_0003);
        base = log_d.size();
        pulse_frame_end();
        wait_idle();
        check_trailer("trl_empty", base, 32'hF000_0000);

        // Frame end during COORD and again during DESC
        base = log_d.size();
        send_feature(16'd7, 10'h3FF, 10'h001, desc_a);
        @(posedge clk);
        #1;
        pulse_frame_end();
        repeat (2) @(posedge clk);
        #1;
        pulse_frame_end();
        wait_idle();
        check("mid_word_count", 32'(log_d.size() - base), 32'(PKT_W + TRL_W));
        check("mid_header", log_d[base], 32'h1007_0000);
        check_trailer("mid_trailer", base + PKT_W, 32'hF000_0001);
        check("mid_trailer_follows", 32'(log_c[base+PKT_W] - log_c[base+PKT_W-1]), 32'd2);

        // Asynchronous reset during DESC word 4
        base = log_d.size();
        send_feature(16'd5, 10'h055, 10'h0AA, desc_a);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 300 && !seen; i++) begin
                @(negedge clk);
                if (log_d.size() >= base + 6) seen = 1'b1;
            end
            if (!seen) check("reset_wait_timeout", 32'd1, 32'd0);
        end
        check("pre_reset_bus_desc4", out_data, 32'hA0A0_0004);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("post_reset_ready_low", 32'(out_feature_ready), 32'd0);
        @(posedge clk);
        #1;
        check("post_reset_ready_high", 32'(out_feature_ready), 32'd1);
        base = log_d.size();
        pulse_frame_end();
        wait_idle();
        check("post_reset_count", 32'(log_d.size() - base), 32'(TRL_W));
        check_trailer("post_reset_trailer", base, 32'hF000_0000);

        // Randomized traffic with random backpressure and frame-end pulses
        bp_mode = 2;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 12)) @(posedge clk);
                    #1;
                    send_feature(16'($urandom()), 10'($urandom()), 10'($urandom()),
                                 {8{$urandom()}});
                end
            end
            begin
                for (int n = 0; n < 25; n++) begin
                    repeat ($urandom_range(3, 50)) @(posedge clk);
                    #1;
                    pulse_frame_end();
                end
            end
        join
        pulse_frame_end();
        wait_idle();
        bp_mode = 0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("[TB] %0d tests run, %0d failed", ntests, nfail + 1);
        $fatal(1, "watchdog");
    end

endmodule
